// File: rtl/counter_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer_ctrl
//  Purpose  : Command-driven sequencer for a WIDTH-bit counter datapath.
//             Accepts START / STOP / PAUSE(toggle) / SET_LIMIT commands over
//             a valid/ready port and steps the count up or down on qualified
//             ticks.  Flags the terminal step with a one-cycle tc pulse and
//             then either reloads (free-running) or halts in DONE (one-shot).
//  Ports    : clock      - system clock, posedge
//             reset      - synchronous reset, active low
//             cmd_valid  - command present
//             cmd_ready  - command can be accepted (high out of reset)
//             cmd_op     - 00 START, 01 STOP, 10 PAUSE, 11 SET_LIMIT
//             cmd_data   - START reload value / SET_LIMIT limit value
//             tick       - count enable in RUN
//             dir_up     - 1 count up toward limit, 0 count down toward 0
//             one_shot   - 1 halt at terminal count, 0 reload and continue
//             count      - current count
//             tc         - one-cycle pulse after the terminal step
//             busy       - RUN or PAUSE
//             done       - DONE state
//             cmd_err    - one-cycle pulse: accepted command illegal in state
//  Revision : 1.0  initial release
// ============================================================================
module counter_sequencer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             tick,
    input  logic             dir_up,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]       c_OP_START = 2'b00;
    localparam logic [1:0]       c_OP_STOP  = 2'b01;
    localparam logic [1:0]       c_OP_PAUSE = 2'b10;
    localparam logic [1:0]       c_OP_LIMIT = 2'b11;
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO     = '0;
    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_limit;
    logic             r_tc;
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             w_tc_nxt;
    logic             w_err_nxt;
    logic             w_accept;
    logic             w_terminal;

    // The controller never back-pressures; ready simply follows the reset
    // pin so that no command can be taken while the block is held in reset.
    assign cmd_ready = reset;
    assign w_accept  = cmd_valid & cmd_ready;

    // Direction is sampled on every step, so the terminal test follows it.
    assign w_terminal = dir_up ? (r_count == r_limit) : (r_count == c_ZERO);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_limit_nxt  = r_limit;
        w_tc_nxt     = 1'b0;
        w_err_nxt    = 1'b0;

        if (w_accept) begin
            // A command always takes priority; any tick this cycle is dropped.
            case (cmd_op)
                c_OP_START: begin
                    w_state_nxt  = S_RUN;
                    w_count_nxt  = cmd_data;
                    w_reload_nxt = cmd_data;
                end
                c_OP_STOP: begin
                    w_state_nxt = S_IDLE;
                end
                c_OP_PAUSE: begin
                    if (r_state == S_RUN) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_state == S_PAUSE) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                c_OP_LIMIT: begin
                    if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
                        w_limit_nxt = cmd_data;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end else if ((r_state == S_RUN) && tick) begin
            if (w_terminal) begin
                w_tc_nxt = 1'b1;
                if (one_shot) begin
                    // Halt holding the terminal value.
                    w_state_nxt = S_DONE;
                end else begin
                    w_count_nxt = r_reload;
                end
            end else if (dir_up) begin
                // Wraps modulo 2^WIDTH, so a start above the limit passes 0.
                w_count_nxt = r_count + c_ONE;
            end else begin
                w_count_nxt = r_count - c_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= c_ZERO;
            r_reload <= c_ZERO;
            r_limit  <= c_ALL_ONES;
            r_tc     <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_limit  <= w_limit_nxt;
            r_tc     <= w_tc_nxt;
            r_err    <= w_err_nxt;
            // Status flags are registered from the next state so they line
            // up with the state register rather than being decoded from it.
            r_busy   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cmd_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sequencer_ctrl
//  Purpose  : Self-checking bench for counter_sequencer_ctrl (WIDTH=4):
//             directed vector table, hand-written multi-cycle sequences and
//             randomized stimulus against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_sequencer_ctrl;

    localparam int W      = 4;
    localparam int MAXV   = (1 << W) - 1;
    localparam logic [1:0] OP_ST = 2'b00;
    localparam logic [1:0] OP_SP = 2'b01;
    localparam logic [1:0] OP_PA = 2'b10;
    localparam logic [1:0] OP_SL = 2'b11;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         tick = 1'b0;
    logic         dir_up = 1'b1;
    logic         one_shot = 1'b1;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
    logic         cmd_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_st     = M_IDLE;
    int m_count  = 0;
    int m_limit  = MAXV;
    int m_reload = 0;
    int m_tc     = 0;
    int m_err    = 0;

    counter_sequencer_ctrl #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .tick      (tick),
        .dir_up    (dir_up),
        .one_shot  (one_shot),
        .count     (count),
        .tc        (tc),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] op;
        int         d;
        logic       t;
        int         c;
        int         tc;
        int         busy;
        int         done;
        int         err;
        int         rdy;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rst, input logic v, input logic [1:0] op,
                                input int d, input logic t, input int c, input int tcv,
                                input int b, input int dn, input int e, input int r);
        vec_t x;
        x.rst = rst; x.v = v; x.op = op; x.d = d; x.t = t;
        x.c = c; x.tc = tcv; x.busy = b; x.done = dn; x.err = e; x.rdy = r;
        return x;
    endfunction

    // Reference model: advances one clock using the current input values.
    task automatic model_update();
        bit term;
        if (!reset) begin
            m_st = M_IDLE; m_count = 0; m_reload = 0; m_limit = MAXV;
            m_tc = 0; m_err = 0;
        end else begin
            m_tc = 0;
            m_err = 0;
            if (cmd_valid) begin
                case (cmd_op)
                    OP_ST: begin m_st = M_RUN; m_count = int'(cmd_data); m_reload = int'(cmd_data); end
                    OP_SP: m_st = M_IDLE;
                    OP_PA: begin
                        if (m_st == M_RUN) m_st = M_PAUSE;
                        else if (m_st == M_PAUSE) m_st = M_RUN;
                        else m_err = 1;
                    end
                    default: begin
                        if (m_st == M_IDLE || m_st == M_DONE) m_limit = int'(cmd_data);
                        else m_err = 1;
                    end
                endcase
            end else if (m_st == M_RUN && tick) begin
                term = dir_up ? (m_count == m_limit) : (m_count == 0);
                if (term) begin
                    m_tc = 1;
                    if (one_shot) m_st = M_DONE;
                    else m_count = m_reload;
                end else if (dir_up) begin
                    m_count = (m_count + 1) % (MAXV + 1);
                end else begin
                    m_count = (m_count + MAXV) % (MAXV + 1);
                end
            end
        end
    endtask

    task automatic cyc();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input int d, input logic t);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = W'(d);
        tick      = t;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int c, input int t, input int b,
                           input int dn, input int e);
        chk({tag, " count"}, int'(count), c);
        chk({tag, " tc"}, int'(tc), t);
        chk({tag, " busy"}, int'(busy), b);
        chk({tag, " done"}, int'(done), dn);
        chk({tag, " cmd_err"}, int'(cmd_err), e);
    endtask

    task automatic chk_model(input string tag);
        chk_out(tag, m_count, m_tc, (m_st == M_RUN || m_st == M_PAUSE) ? 1 : 0,
                (m_st == M_DONE) ? 1 : 0, m_err);
        chk({tag, " cmd_ready"}, int'(cmd_ready), int'(reset));
    endtask

    initial begin : main
        int exp_c[6];
        int exp_t[6];

        // Reset, limit 5 one-shot up count, illegal commands, STOP vs tick.
        vecs[0]  = mk(0, 0, OP_ST, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, OP_ST, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, OP_ST, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(1, 1, OP_SL, 5, 0,  0, 0, 0, 0, 0, 1);
        vecs[4]  = mk(1, 1, OP_ST, 2, 1,  2, 0, 1, 0, 0, 1);
        vecs[5]  = mk(1, 0, OP_ST, 0, 1,  3, 0, 1, 0, 0, 1);
        vecs[6]  = mk(1, 0, OP_ST, 0, 1,  4, 0, 1, 0, 0, 1);
        vecs[7]  = mk(1, 0, OP_ST, 0, 1,  5, 0, 1, 0, 0, 1);
        vecs[8]  = mk(1, 0, OP_ST, 0, 1,  5, 1, 0, 1, 0, 1);
        vecs[9]  = mk(1, 0, OP_ST, 0, 1,  5, 0, 0, 1, 0, 1);
        vecs[10] = mk(1, 1, OP_PA, 0, 0,  5, 0, 0, 1, 1, 1);
        vecs[11] = mk(1, 1, OP_SP, 0, 0,  5, 0, 0, 0, 0, 1);
        vecs[12] = mk(1, 1, OP_PA, 0, 0,  5, 0, 0, 0, 1, 1);
        vecs[13] = mk(1, 1, OP_ST, 4, 1,  4, 0, 1, 0, 0, 1);
        vecs[14] = mk(1, 1, OP_SL, 7, 1,  4, 0, 1, 0, 1, 1);
        vecs[15] = mk(1, 0, OP_ST, 0, 1,  5, 0, 1, 0, 0, 1);
        vecs[16] = mk(1, 0, OP_ST, 0, 1,  5, 1, 0, 1, 0, 1);
        vecs[17] = mk(1, 1, OP_ST, 9, 1,  9, 0, 1, 0, 0, 1);
        vecs[18] = mk(1, 0, OP_ST, 0, 1, 10, 0, 1, 0, 0, 1);
        vecs[19] = mk(1, 1, OP_SP, 0, 1, 10, 0, 0, 0, 0, 1);

        dir_up   = 1'b1;
        one_shot = 1'b1;
        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].t);
            cyc();
            chk_out($sformatf("vec%0d", i), vecs[i].c, vecs[i].tc, vecs[i].busy,
                    vecs[i].done, vecs[i].err);
            chk($sformatf("vec%0d cmd_ready", i), int'(cmd_ready), vecs[i].rdy);
        end

        // Free-running down count with pause toggle.
        dir_up   = 1'b0;
        one_shot = 1'b0;
        drive(1, OP_ST, 3, 1); cyc(); chk_out("down start", 3, 0, 1, 0, 0);
        exp_c = '{2, 1, 0, 3, 2, 1};
        exp_t = '{0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive(0, OP_ST, 0, 1); cyc();
            chk_out($sformatf("down step%0d", i), exp_c[i], exp_t[i], 1, 0, 0);
        end
        drive(1, OP_PA, 0, 1); cyc(); chk_out("pause on", 1, 0, 1, 0, 0);
        drive(0, OP_ST, 0, 1); cyc(); chk_out("paused tick", 1, 0, 1, 0, 0);
        drive(1, OP_PA, 0, 1); cyc(); chk_out("pause off", 1, 0, 1, 0, 0);
        drive(0, OP_ST, 0, 1); cyc(); chk_out("resumed", 0, 0, 1, 0, 0);
        drive(0, OP_ST, 0, 1); cyc(); chk_out("down reload", 3, 1, 1, 0, 0);

        // Start above the limit wraps through zero.
        drive(1, OP_SP, 0, 0); cyc();
        drive(1, OP_SL, 4, 0); cyc();
        dir_up   = 1'b1;
        one_shot = 1'b1;
        drive(1, OP_ST, 14, 1); cyc(); chk_out("wrap start", 14, 0, 1, 0, 0);
        exp_c = '{15, 0, 1, 2, 3, 4};
        for (int i = 0; i < 6; i++) begin
            drive(0, OP_ST, 0, 1); cyc();
            chk_out($sformatf("wrap step%0d", i), exp_c[i], 0, 1, 0, 0);
        end
        drive(0, OP_ST, 0, 1); cyc(); chk_out("wrap term", 4, 1, 0, 1, 0);

        // Reset mid-run restores count and limit.
        one_shot = 1'b0;
        drive(1, OP_ST, 7, 1); cyc();
        drive(0, OP_ST, 0, 1); cyc();
        drive(0, OP_ST, 0, 1); cyc(); chk_out("pre-reset", 9, 0, 1, 0, 0);
        reset = 1'b0; cyc(); chk_out("mid reset", 0, 0, 0, 0, 0);
        chk("mid reset cmd_ready", int'(cmd_ready), 0);
        reset = 1'b1;
        one_shot = 1'b1;
        drive(1, OP_ST, 14, 1); cyc(); chk_out("post reset start", 14, 0, 1, 0, 0);
        drive(0, OP_ST, 0, 1); cyc(); chk_out("post reset step", 15, 0, 1, 0, 0);
        drive(0, OP_ST, 0, 1); cyc(); chk_out("limit restored", 15, 1, 0, 1, 0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            cmd_valid = ($urandom_range(0, 99) < 25);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = W'($urandom_range(0, MAXV));
            tick      = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 10) dir_up = ~dir_up;
            if ($urandom_range(0, 99) < 10) one_shot = ~one_shot;
            cyc();
            chk_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
